// File: rtl/audio_pkg.sv
// Shared types and fixed source levels for the audio mixer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_pkg;

    typedef enum logic [1:0] {
        PAN_OFF = 2'b00,
        PAN_L   = 2'b01,
        PAN_R   = 2'b10,
        PAN_LR  = 2'b11
    } pan_t;

    localparam logic [7:0] MIX_LVL_BEEPER   = 8'h60;
    localparam logic [7:0] MIX_LVL_TAPE_OUT = 8'h18;
    localparam logic [7:0] MIX_LVL_TAPE_IN  = 8'h18;

    function automatic logic [7:0] atten(input logic [7:0] smp, input logic [1:0] shift);
        return smp >> shift;
    endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator; the adder carry is the output bitstream.
// Latency: din affects dout on the next clk28 edge.
// Backpressure: none, consumes din every cycle.
module sigma_delta_dac #(
    parameter int W = 8
) (
    input  logic         clk28,
    input  logic         usrrst_n,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] err;
    logic [W:0]   sum;

    assign sum = {1'b0, err} + {1'b0, din};

    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            err  <= '0;
            dout <= 1'b0;
        end else begin
            err  <= sum[W-1:0];
            dout <= sum[W];
        end
    end

endmodule

// File: rtl/audio_mixer_n.sv
// Time-multiplexed stereo mixer (CH_COUNT PCM + beeper/tape) feeding two sigma-delta DACs; MIXER_CLIP_EN adds saturation.
// Latency: input to mix at most CH_COUNT+4 cycles, mix to DAC one cycle.
// Backpressure: none, each input is sampled in its own slot only.
module audio_mixer_n #(
    parameter int CH_COUNT = 4,
    parameter int HEADROOM = 1
) (
    input  logic                  clk28,
    input  logic                  usrrst_n,
    input  logic                  en,
    input  logic [CH_COUNT*8-1:0] ch_data,
    input  logic [CH_COUNT*2-1:0] ch_gain,
    input  logic [CH_COUNT*2-1:0] ch_pan,
    input  logic                  beeper,
    input  logic                  tape_out,
    input  logic                  tape_in,
    output logic                  dac_l,
    output logic                  dac_r,
    output logic                  mix_strobe,
    output logic                  clip
);

    import audio_pkg::*;

    localparam int P      = CH_COUNT + 4;
    localparam int ACC_W  = 8 + $clog2(CH_COUNT + 3);
    localparam int SLOT_W = $clog2(P);

    localparam logic [SLOT_W-1:0] SLOT_BEEP  = SLOT_W'(CH_COUNT);
    localparam logic [SLOT_W-1:0] SLOT_TOUT  = SLOT_W'(CH_COUNT + 1);
    localparam logic [SLOT_W-1:0] SLOT_TIN   = SLOT_W'(CH_COUNT + 2);
    localparam logic [SLOT_W-1:0] SLOT_LATCH = SLOT_W'(P - 1);

    logic [SLOT_W-1:0] slot;
    logic [ACC_W-1:0]  acc_l, acc_r;
    logic [7:0]        mix_l, mix_r;
    logic [7:0]        term;
    logic              to_l, to_r;
    logic [7:0]        scl_l, scl_r;
    pan_t              pan;

    // Select the single source owning the current slot.
    always_comb begin
        term = 8'h00;
        to_l = 1'b0;
        to_r = 1'b0;
        pan  = PAN_OFF;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (slot == SLOT_W'(i)) begin
                pan  = pan_t'(ch_pan[2*i +: 2]);
                term = atten(ch_data[8*i +: 8], ch_gain[2*i +: 2]);
                to_l = pan[0];
                to_r = pan[1];
            end
        end
        if (slot == SLOT_BEEP) begin
            term = beeper ? MIX_LVL_BEEPER : 8'h00;
            to_l = 1'b1;
            to_r = 1'b1;
        end
        if (slot == SLOT_TOUT) begin
            term = tape_out ? MIX_LVL_TAPE_OUT : 8'h00;
            to_l = 1'b1;
            to_r = 1'b1;
        end
        if (slot == SLOT_TIN) begin
            term = tape_in ? MIX_LVL_TAPE_IN : 8'h00;
            to_l = 1'b1;
            to_r = 1'b1;
        end
        if (!en) begin
            term = 8'h00;
        end
    end

`ifdef MIXER_CLIP_EN
    logic [ACC_W-1:0] shf_l, shf_r;
    logic             sat_l, sat_r;

    assign shf_l = acc_l >> HEADROOM;
    assign shf_r = acc_r >> HEADROOM;
    assign sat_l = shf_l > ACC_W'(255);
    assign sat_r = shf_r > ACC_W'(255);
    assign scl_l = sat_l ? 8'hFF : shf_l[7:0];
    assign scl_r = sat_r ? 8'hFF : shf_r[7:0];

    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            clip <= 1'b0;
        end else if (slot == SLOT_LATCH) begin
            clip <= sat_l | sat_r;
        end
    end
`else
    // Top byte of an accumulator sized for the worst-case sum can never exceed 255.
    assign scl_l = acc_l[ACC_W-1 -: 8];
    assign scl_r = acc_r[ACC_W-1 -: 8];
    assign clip  = 1'b0;
`endif

    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            slot       <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            mix_l      <= 8'h00;
            mix_r      <= 8'h00;
            mix_strobe <= 1'b0;
        end else begin
            mix_strobe <= (slot == SLOT_LATCH);
            if (slot == SLOT_LATCH) begin
                slot  <= '0;
                acc_l <= '0;
                acc_r <= '0;
                mix_l <= scl_l;
                mix_r <= scl_r;
            end else begin
                slot <= slot + 1'b1;
                if (to_l) begin
                    acc_l <= acc_l + ACC_W'(term);
                end
                if (to_r) begin
                    acc_r <= acc_r + ACC_W'(term);
                end
            end
        end
    end

    sigma_delta_dac #(.W(8)) u_dac_l (
        .clk28    (clk28),
        .usrrst_n (usrrst_n),
        .din      (mix_l),
        .dout     (dac_l)
    );

    sigma_delta_dac #(.W(8)) u_dac_r (
        .clk28    (clk28),
        .usrrst_n (usrrst_n),
        .din      (mix_r),
        .dout     (dac_r)
    );

endmodule
